// File: rtl/bus_bridge_reg_if.sv
// rtl/bus_bridge_reg_if.sv - bus bundle between the datapath bridge and its user
//
// Purpose: groups the data buses, open requests, hold control and the
// registered results/flags of bus_bridge_reg into one interface.
// Ports (signals):
//   bus_in    NBUS*WIDTH  bus b value at [b*WIDTH +: WIDTH]
//   open_req  NBUS*NBUS   bit s*NBUS+d: drive bus d from bus s
//   hold      1           freeze all registered outputs this cycle
//   bus_out   NBUS*WIDTH  registered resolved bus values
//   driven    NBUS        registered: bus d driven from another bus
//   conflict  1           registered: >1 source requested some dest
//   loop_err  1           registered: request graph had a cycle
//   err_count 8           saturating count of erroneous updates
// Modports: master drives the inputs, slave is the bridge itself.
interface bus_bridge_reg_if #(
  parameter int WIDTH = 8,
  parameter int NBUS  = 3
);
  logic [NBUS*WIDTH-1:0] bus_in;
  logic [NBUS*NBUS-1:0]  open_req;
  logic                  hold;
  logic [NBUS*WIDTH-1:0] bus_out;
  logic [NBUS-1:0]       driven;
  logic                  conflict;
  logic                  loop_err;
  logic [7:0]            err_count;

  modport master (
    output bus_in, open_req, hold,
    input  bus_out, driven, conflict, loop_err, err_count
  );

  modport slave (
    input  bus_in, open_req, hold,
    output bus_out, driven, conflict, loop_err, err_count
  );
endinterface

// File: rtl/bus_bridge_reg.sv
// rtl/bus_bridge_reg.sv - registered NBUS-way datapath bus bridge
//
// Purpose: routes internal buses through a src->dst request matrix with
// chained forwarding, fixed lowest-index priority, and cycle detection.
// All results are registered (one cycle latency) and can be frozen by hold.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  synchronous active-high reset (beats hold)
//   bus  slave modport of bus_bridge_reg_if (data, requests, hold, results)
module bus_bridge_reg #(
  parameter int WIDTH = 8,
  parameter int NBUS  = 3
) (
  input  logic             clk,
  input  logic             rst,
  bus_bridge_reg_if.slave  bus
);
  localparam int IDXW = $clog2(NBUS);

  logic [IDXW-1:0]       winner [NBUS];
  logic [NBUS-1:0]       has_win;
  logic                  nxt_conflict;
  logic [NBUS*WIDTH-1:0] nxt_bus_out;
  logic [NBUS-1:0]       nxt_driven;
  logic                  nxt_loop;
  logic [IDXW-1:0]       cur;

  // Per-destination source pick: ascending scan, so the first hit is the
  // lowest index; any later hit for the same dest is a conflict.
  always_comb begin
    nxt_conflict = 1'b0;
    has_win      = '0;
    for (int d = 0; d < NBUS; d++) begin
      winner[d] = '0;
      for (int s = 0; s < NBUS; s++) begin
        if (s != d && bus.open_req[s*NBUS+d]) begin
          if (has_win[d]) begin
            nxt_conflict = 1'b1;
          end else begin
            has_win[d] = 1'b1;
            winner[d]  = IDXW'(s);
          end
        end
      end
    end
  end

  // Follow winner links NBUS-1 hops; an acyclic chain always lands on an
  // undriven root within that many hops, so a still-driven bus means a loop.
  always_comb begin
    nxt_bus_out = '0;
    nxt_driven  = '0;
    nxt_loop    = 1'b0;
    cur         = '0;
    for (int d = 0; d < NBUS; d++) begin
      cur = IDXW'(d);
      for (int h = 0; h < NBUS - 1; h++) begin
        if (has_win[cur]) begin
          cur = winner[cur];
        end
      end
      if (has_win[cur]) begin
        nxt_bus_out[d*WIDTH +: WIDTH] = bus.bus_in[d*WIDTH +: WIDTH];
        nxt_loop = 1'b1;
      end else begin
        nxt_bus_out[d*WIDTH +: WIDTH] = bus.bus_in[cur*WIDTH +: WIDTH];
        nxt_driven[d] = has_win[d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.bus_out   <= '0;
      bus.driven    <= '0;
      bus.conflict  <= 1'b0;
      bus.loop_err  <= 1'b0;
      bus.err_count <= '0;
    end else if (!bus.hold) begin
      bus.bus_out  <= nxt_bus_out;
      bus.driven   <= nxt_driven;
      bus.conflict <= nxt_conflict;
      bus.loop_err <= nxt_loop;
      if ((nxt_conflict || nxt_loop) && bus.err_count != 8'hff) begin
        bus.err_count <= bus.err_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_bus_bridge_reg.sv
// tb/tb_bus_bridge_reg.sv - scoreboard bench for bus_bridge_reg
module tb_bus_bridge_reg;
  localparam int W = 8;
  localparam int N = 3;

  typedef struct packed {
    logic [N*W-1:0] bo;
    logic [N-1:0]   dr;
    logic           cf;
    logic           le;
    logic [7:0]     ec;
  } exp_t;

  logic clk;
  logic rst;
  bus_bridge_reg_if #(.WIDTH(W), .NBUS(N)) bif ();
  bus_bridge_reg #(.WIDTH(W), .NBUS(N)) dut (.clk(clk), .rst(rst), .bus(bif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb_q[$];
  exp_t m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walks each chain with a visited set instead of a hop budget.
  task automatic model_step(input logic r, input logic [N*W-1:0] bi,
                            input logic [N*N-1:0] oreq, input logic h);
    int  win [N];
    bit  any_conf;
    bit  any_loop;
    int  cnt;
    int  c;
    logic [N-1:0] seen;
    bit  done;
    bit  lp;
    if (r) begin
      m = '0;
      return;
    end
    if (h) return;
    any_conf = 0;
    any_loop = 0;
    for (int d = 0; d < N; d++) begin
      win[d] = -1;
      cnt = 0;
      for (int s = N - 1; s >= 0; s--) begin
        if (s != d && oreq[s*N+d]) begin
          win[d] = s;
          cnt++;
        end
      end
      if (cnt > 1) any_conf = 1;
    end
    for (int d = 0; d < N; d++) begin
      seen = '0;
      c = d;
      done = 0;
      lp = 0;
      for (int k = 0; k <= N; k++) begin
        if (!done) begin
          if (seen[c]) begin
            lp = 1;
            done = 1;
          end else begin
            seen[c] = 1'b1;
            if (win[c] < 0) done = 1;
            else c = win[c];
          end
        end
      end
      if (lp) begin
        m.bo[d*W +: W] = bi[d*W +: W];
        m.dr[d] = 1'b0;
        any_loop = 1;
      end else begin
        m.bo[d*W +: W] = bi[c*W +: W];
        m.dr[d] = (win[d] >= 0);
      end
    end
    m.cf = any_conf;
    m.le = any_loop;
    if ((any_conf || any_loop) && m.ec != 8'hff) m.ec = m.ec + 8'd1;
  endtask

  task automatic apply(input logic r, input logic [N*W-1:0] bi,
                       input logic [N*N-1:0] oreq, input logic h);
    exp_t e;
    @(negedge clk);
    rst = r;
    bif.bus_in = bi;
    bif.open_req = oreq;
    bif.hold = h;
    model_step(r, bi, oreq, h);
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("bus_out", 64'(bif.bus_out), 64'(e.bo));
    check("driven", 64'(bif.driven), 64'(e.dr));
    check("conflict", 64'(bif.conflict), 64'(e.cf));
    check("loop_err", 64'(bif.loop_err), 64'(e.le));
    check("err_count", 64'(bif.err_count), 64'(e.ec));
  endtask

  localparam logic [N*W-1:0] BASE = 24'h332211;

  initial begin
    rst = 1'b1;
    bif.bus_in = '0;
    bif.open_req = '0;
    bif.hold = 1'b0;
    m = '0;

    // 1: reset with random inputs, then pass-through
    apply(1'b1, 24'($urandom), 9'($urandom), 1'($urandom));
    apply(1'b1, 24'($urandom), 9'($urandom), 1'($urandom));
    check("rst_bus_out", 64'(bif.bus_out), 64'h0);
    check("rst_err_count", 64'(bif.err_count), 64'h0);
    apply(1'b0, BASE, 9'h000, 1'b0);
    check("pass_bus_out", 64'(bif.bus_out), 64'h332211);
    check("pass_driven", 64'(bif.driven), 64'h0);

    // 2: single 0->1
    apply(1'b0, BASE, 9'h002, 1'b0);
    check("single_bus_out", 64'(bif.bus_out), 64'h331111);
    check("single_driven", 64'(bif.driven), 64'h2);

    // 3: chain 0->1->2
    apply(1'b0, BASE, 9'h022, 1'b0);
    check("chain_bus_out", 64'(bif.bus_out), 64'h111111);
    check("chain_driven", 64'(bif.driven), 64'h6);
    check("chain_loop", 64'(bif.loop_err), 64'h0);

    // 4: conflict on dest 2, src 0 wins
    apply(1'b0, BASE, 9'h024, 1'b0);
    check("conf_bus_out", 64'(bif.bus_out), 64'h112211);
    check("conf_flag", 64'(bif.conflict), 64'h1);
    check("conf_count", 64'(bif.err_count), 64'h1);

    // 5: loop 0<->1, then saturate the counter
    apply(1'b0, BASE, 9'h00a, 1'b0);
    check("loop_bus_out", 64'(bif.bus_out), 64'h332211);
    check("loop_driven", 64'(bif.driven), 64'h0);
    check("loop_flag", 64'(bif.loop_err), 64'h1);
    check("loop_count", 64'(bif.err_count), 64'h2);
    for (int i = 0; i < 256; i++) apply(1'b0, 24'($urandom), 9'h00a, 1'b0);
    check("sat_count", 64'(bif.err_count), 64'hff);

    // 6: hold freezes everything; reset beats hold
    apply(1'b0, BASE, 9'h002, 1'b0);
    apply(1'b0, 24'h998877, 9'h024, 1'b1);
    check("hold_bus_out", 64'(bif.bus_out), 64'h331111);
    check("hold_count", 64'(bif.err_count), 64'hff);
    apply(1'b1, 24'h445566, 9'h024, 1'b1);
    check("rst_hold_count", 64'(bif.err_count), 64'h0);
    check("rst_hold_bus_out", 64'(bif.bus_out), 64'h0);

    // Random mix against the reference model
    for (int i = 0; i < 300; i++) begin
      apply(($urandom_range(0, 39) == 0), 24'($urandom),
            9'($urandom & $urandom), ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
